// File: rtl/b8_pipe_pkg.sv
// b8_pipe_pkg: widths and the write-back payload shared by the way pipeline stages
package b8_pipe_pkg;

    localparam int DATA_W  = 64;
    localparam int RADDR_W = 5;
    localparam int PID_W   = 2;

    typedef struct packed {
        logic               rdWriteEnable;
        logic [RADDR_W-1:0] rdAddr;
        logic [DATA_W-1:0]  rdData;
        logic [PID_W-1:0]   pID;
`ifdef DebugMode
        logic [31:0]        instAddr;
        logic [31:0]        inst;
`endif
    } wb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry valid/ready skid buffer with registered ready and flush
module pipe_skid_buf #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    logic main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic in_fire, out_fire, main_ld, skid_ld;
    T     main_q, skid_q;

    assign ready_o  = ~skid_v_q;
    assign valid_o  = main_v_q;
    assign data_o   = main_q;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = main_v_q & ready_i;

    // Next-state: main refills from skid when it drains, otherwise from the input; skid only catches stalled input
    always_comb begin
        main_ld  = ~flush_i & (skid_v_q ? out_fire : (in_fire & (~main_v_q | out_fire)));
        skid_ld  = ~flush_i & ~skid_v_q & main_v_q & ~out_fire & in_fire;
        main_v_d = ~flush_i & (skid_v_q | (main_v_q & ~out_fire) | in_fire);
        skid_v_d = ~flush_i & (skid_v_q ? ~out_fire : skid_ld);
    end

    // Valid flags and payload slots; payload only moves on capture so a held entry stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            if (main_ld) main_q <= skid_v_q ? skid_q : data_i;
            if (skid_ld) skid_q <= data_i;
        end
    end

endmodule

// File: rtl/mem_wb_reg_way0.sv
// mem_wb_reg_way0: way0 MEM->WB pipeline register built on a flushable skid buffer
module mem_wb_reg_way0
    import b8_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               rdWriteEnable_i,
    input  logic [RADDR_W-1:0] rdAddr_i,
    input  logic [DATA_W-1:0]  rdData_i,
    input  logic [PID_W-1:0]   way0_pID_i,
`ifdef DebugMode
    input  logic [31:0]        instAddr_i,
    input  logic [31:0]        inst_i,
    output logic [31:0]        instAddr_o,
    output logic [31:0]        inst_o,
`endif
    output logic               valid_o,
    input  logic               ready_i,
    output logic               rdWriteEnable_o,
    output logic [RADDR_W-1:0] rdAddr_o,
    output logic [DATA_W-1:0]  rdData_o,
    output logic [PID_W-1:0]   way0_pID_o
);

    wb_payload_t in_p, out_p;

    // Pack the memory-stage fields into one payload word
    always_comb begin
        in_p               = '0;
        in_p.rdWriteEnable = rdWriteEnable_i;
        in_p.rdAddr        = rdAddr_i;
        in_p.rdData        = rdData_i;
        in_p.pID           = way0_pID_i;
`ifdef DebugMode
        in_p.instAddr      = instAddr_i;
        in_p.inst          = inst_i;
`endif
    end

    pipe_skid_buf #(.T(wb_payload_t)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (in_p),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (out_p)
    );

    assign rdWriteEnable_o = out_p.rdWriteEnable;
    assign rdAddr_o        = out_p.rdAddr;
    assign rdData_o        = out_p.rdData;
    assign way0_pID_o      = out_p.pID;
`ifdef DebugMode
    assign instAddr_o      = out_p.instAddr;
    assign inst_o          = out_p.inst;
`endif

endmodule

// File: tb/tb_mem_wb_reg_way0.sv
// tb_mem_wb_reg_way0: directed and randomised checks of the way0 MEM->WB register against a FIFO model
module tb_mem_wb_reg_way0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        rdWriteEnable_i = 1'b0;
    logic [4:0]  rdAddr_i = '0;
    logic [63:0] rdData_i = '0;
    logic [1:0]  way0_pID_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        rdWriteEnable_o;
    logic [4:0]  rdAddr_o;
    logic [63:0] rdData_o;
    logic [1:0]  way0_pID_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [71:0] q[$];

    mem_wb_reg_way0 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .rdWriteEnable_i (rdWriteEnable_i),
        .rdAddr_i        (rdAddr_i),
        .rdData_i        (rdData_i),
        .way0_pID_i      (way0_pID_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .rdWriteEnable_o (rdWriteEnable_o),
        .rdAddr_o        (rdAddr_o),
        .rdData_o        (rdData_o),
        .way0_pID_o      (way0_pID_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] a, input logic [63:0] d, input logic [1:0] p);
        valid_i = v;
        rdWriteEnable_i = we;
        rdAddr_i = a;
        rdData_i = d;
        way0_pID_i = p;
    endtask

    task automatic step();
        logic inf, outf;
        logic [71:0] e;
        inf  = valid_i && ready_o;
        outf = valid_o && ready_i;
        if (outf) begin
            if (q.size() == 0) check("pop_on_empty", 72'd1, 72'd0);
            else begin
                e = q.pop_front();
                check("out_payload", {rdWriteEnable_o, rdAddr_o, rdData_o, way0_pID_o}, e);
            end
        end
        if (flush_i) q.delete();
        else if (inf) q.push_back({rdWriteEnable_i, rdAddr_i, rdData_i, way0_pID_i});
        @(posedge clk);
        #1;
        check("valid_o", 72'(valid_o), 72'(q.size() > 0));
        check("ready_o", 72'(ready_o), 72'(q.size() < 2));
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("rst_valid", 72'(valid_o), 72'd0);
        check("rst_ready", 72'(ready_o), 72'd1);
        check("rst_payload", {rdWriteEnable_o, rdAddr_o, rdData_o, way0_pID_o}, 72'd0);
        rst_n = 1'b1;
        repeat (5) step();
        check("idle_payload", {rdWriteEnable_o, rdAddr_o, rdData_o, way0_pID_o}, 72'd0);

        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i[0], 5'(i), 64'h1000 + 64'(i), 2'(i));
            step();
            check("stream_rd", 72'(rdAddr_o), 72'(i));
            check("stream_data", 72'(rdData_o), 72'h1000 + 72'(i));
        end
        drive(1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
        step();

        ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd3, 64'hAA, 2'd1);
        step();
        check("bp_hold_a", 72'(rdAddr_o), 72'd3);
        drive(1'b1, 1'b0, 5'd4, 64'hBB, 2'd2);
        step();
        check("bp_still_a", 72'(rdData_o), 72'hAA);
        check("bp_ready_low", 72'(ready_o), 72'd0);
        drive(1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
        step();
        check("bp_stable_a", 72'(rdAddr_o), 72'd3);
        ready_i = 1'b1;
        step();
        check("bp_then_b", 72'(rdAddr_o), 72'd4);
        check("bp_ready_back", 72'(ready_o), 72'd1);
        step();

        ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd5, 64'h55, 2'd0);
        step();
        drive(1'b1, 1'b1, 5'd6, 64'h66, 2'd1);
        step();
        flush_i = 1'b1;
        drive(1'b1, 1'b1, 5'd9, 64'h99, 2'd3);
        step();
        check("flush_valid", 72'(valid_o), 72'd0);
        check("flush_ready", 72'(ready_o), 72'd1);
        flush_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
        ready_i = 1'b1;
        repeat (3) step();

        ready_i = 1'b0;
        drive(1'b1, 1'b0, 5'd7, 64'h77, 2'd2);
        step();
        drive(1'b1, 1'b1, 5'd8, 64'h88, 2'd3);
        step();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
        check("ar_skid_full", 72'(ready_o), 72'd0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid_now", 72'(valid_o), 72'd0);
        check("ar_ready_now", 72'(ready_o), 72'd1);
        q.delete();
        #1 rst_n = 1'b1;
        ready_i = 1'b1;
        repeat (4) step();

        for (int i = 0; i < 10000; i++) begin
            flush_i = ($urandom_range(0, 63) == 0);
            ready_i = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 7, 1'($urandom), 5'($urandom), {$urandom, $urandom}, 2'($urandom));
            step();
        end
        flush_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
        ready_i = 1'b1;
        repeat (3) step();
        check("drain_empty", 72'(q.size()), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
